imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the IF stage instruction-memory write port (i_write_en / i_addr_wr / i_data). It takes a byte stream from the debug UART receiver, packs four bytes MSB-first into 32-bit instruction words, and writes them to consecutive word addresses starting at 0. It holds the pipeline frozen while loading, and reports done or error to the debug unit.

Parameters:
ADDR_WIDTH, 32, width of o_addr_wr (byte address).
MEM_DEPTH_WORDS, 64, instruction memory capacity in words.
HALT_WORD, 32'hFFFFFFFF, end-of-program marker word.
TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes of one word.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_reset  input  1  synchronous, active-low reset.
i_start  input  1  single-cycle load command from the debug unit.
i_rx_data  input  8  received byte.
i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid.
o_write_en  output  1  to IF i_write_en; one-cycle pulse per word.
o_addr_wr  output  ADDR_WIDTH  to IF i_addr_wr; byte address, multiple of 4.
o_data  output  32  to IF i_data; assembled instruction word.
o_cpu_hold  output  1  high while loading; drives pipeline stall and keeps IF i_read_en low.
o_done  output  1  level; load finished successfully.
o_error  output  2  00 none, 01 timeout, 10 overflow; level.
o_word_count  output  ADDR_WIDTH  words written in the current or last load.

Behaviour:
- Reset (i_reset=0 at an edge): state IDLE; every output 0; internal address, byte count and timeout counter 0. Reset mid-load abandons the load. Any partial word is discarded with no write.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: i_rx_valid is ignored. When i_start=1, go to RECV; set address 0, byte count 0, o_word_count 0, o_cpu_hold 1; clear o_done and o_error.
- RECV: each i_rx_valid shifts the byte in as word = {word[23:0], i_rx_data} and increments the byte count (0..3).
  - When the 4th byte is accepted at edge N, the state is WRITE and o_write_en=1 during cycle N+1.
- WRITE: lasts exactly one cycle.
  - o_write_en=1, o_addr_wr=current address, o_data=word.
  - At the next edge: address += 4 and o_word_count += 1.
  - Next state:
    - HALT_WORD → DONE. The halt word itself is written.
    - Otherwise, if the new address equals MEM_DEPTH_WORDS*4 → ERROR with code 10.
    - Otherwise → RECV with byte count 0.
  - A byte arriving during WRITE is captured as byte 0 of the next word. No byte is lost.
- o_addr_wr and o_data hold their last written values when o_write_en=0.
- Timeout: the counter runs only in RECV with byte count ≠ 0 and is cleared on every accepted byte. Reaching TIMEOUT_CYCLES → ERROR with code 01; the partial word is not written.
- DONE: o_done=1, o_cpu_hold=0; i_rx_valid is ignored. i_start restarts a full load from address 0.
- ERROR: o_error holds its code, o_cpu_hold=0, o_done=0. i_start restarts as from IDLE.
- i_start in RECV or WRITE is ignored.
- i_start and i_rx_valid in the same IDLE cycle: the start is taken and the byte is dropped.
- Address arithmetic is unsigned and never wraps: overflow is caught before address MEM_DEPTH_WORDS*4 can be written.

Decomposition:
- Shared package imem_loader_pkg: state encoding, error codes (ERR_NONE, ERR_TIMEOUT, ERR_OVERFLOW), default HALT_WORD.
- One sub-module, byte_packer: 32-bit shift register, 2-bit byte counter, timeout counter. Outputs word_ready and timeout pulses.
- The top level holds the FSM, address counter and write port.

Test Plan:
- Reset held low for 2 edges, then released → all outputs 0, state IDLE. i_rx_valid pulses in IDLE → no o_write_en.
- Start; bytes 20 08 00 05 20 09 00 0A FF FF FF FF → writes (0,20080005), (4,2009000A), (8,FFFFFFFF). o_done=1, o_word_count=3, o_cpu_hold low after the last write.
- Back-to-back bytes, including one during the WRITE cycle → every o_write_en exactly 1 cycle, 1 cycle after the 4th byte. No byte lost; the second word is correct.
- 3 bytes, then silence of TIMEOUT_CYCLES → o_error=01, no write for the partial word, o_cpu_hold=0.
- MEM_DEPTH_WORDS=4 with 4 non-halt words → 4 writes at 0/4/8/12, then o_error=10; no write to address 16.
- Reset asserted after 2 bytes of a word, then a fresh start with 200C0019 FFFFFFFF → first write (0,200C0019); the old partial bytes have no effect.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// error codes and the default end-of-program marker.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_OVERFLOW = 2'b10
    } err_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_if.sv
// Bundle between the debug unit / UART receiver (master) and the loader
// (slave). The loader's outputs feed the IF-stage write port and the
// pipeline stall logic.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  i_start;
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_write_en;
    logic [ADDR_WIDTH-1:0] o_addr_wr;
    logic [31:0]           o_data;
    logic                  o_cpu_hold;
    logic                  o_done;
    err_t                  o_error;
    logic [ADDR_WIDTH-1:0] o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_write_en, o_addr_wr, o_data, o_cpu_hold, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_write_en, o_addr_wr, o_data, o_cpu_hold, o_done, o_error, o_word_count
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs incoming bytes MSB-first into 32-bit words and watches for the
// byte stream stalling in the middle of a word.
module byte_packer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        clear,       // restart packing from byte 0
    input  logic        enable,      // bytes are accepted only when set
    input  logic        timer_en,    // idle timer may run
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word_next,   // word including the byte on rx_data
    output logic        word_ready,  // 4th byte accepted this cycle
    output logic        timeout      // idle limit reached this cycle
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Only the three most recent bytes need storing; the fourth completes
    // the word combinationally so the writer can register it on the same edge.
    logic [23:0]   word;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] idle_cnt;
    logic          accept;
    logic          timer_tick;

    assign accept     = enable && rx_valid;
    assign word_next  = {word, rx_data};
    assign word_ready = accept && (byte_cnt == 2'd3);
    assign timer_tick = timer_en && !accept && (byte_cnt != 2'd0);
    assign timeout    = timer_tick && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Shift register, byte counter and mid-word idle counter.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!i_reset || clear) begin
            word     <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else if (accept) begin
            word     <= word_next[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= '0;
        end else if (timer_tick) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program from the debug UART byte stream into instruction memory,
// freezing the pipeline while loading and reporting done / error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          MEM_DEPTH_WORDS = 64,
    parameter logic [31:0] HALT_WORD       = DEFAULT_HALT_WORD,
    parameter int          TIMEOUT_CYCLES  = 1024
) (
    input  logic         i_clk,
    input  logic         i_reset,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH_WORDS * 4);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  start_load;
    logic [31:0]           word_next;
    logic                  word_ready;
    logic                  timeout;

    // Start is honoured only when no load is in progress.
    assign start_load = bus.i_start &&
                        (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign addr_next  = addr + ADDR_WIDTH'(4);

    byte_packer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_packer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .clear      (start_load),
        .enable     (state == S_RECV || state == S_WRITE),
        .timer_en   (state == S_RECV),
        .rx_data    (bus.i_rx_data),
        .rx_valid   (bus.i_rx_valid),
        .word_next  (word_next),
        .word_ready (word_ready),
        .timeout    (timeout)
    );

    // Load sequencer with registered write port and status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state            <= S_IDLE;
            addr             <= '0;
            bus.o_write_en   <= 1'b0;
            bus.o_addr_wr    <= '0;
            bus.o_data       <= '0;
            bus.o_cpu_hold   <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_error      <= ERR_NONE;
            bus.o_word_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_load) begin
                        state            <= S_RECV;
                        addr             <= '0;
                        bus.o_word_count <= '0;
                        bus.o_cpu_hold   <= 1'b1;
                        bus.o_done       <= 1'b0;
                        bus.o_error      <= ERR_NONE;
                    end
                end
                S_RECV: begin
                    if (word_ready) begin
                        state          <= S_WRITE;
                        bus.o_write_en <= 1'b1;
                        bus.o_addr_wr  <= addr;
                        bus.o_data     <= word_next;
                    end else if (timeout) begin
                        state          <= S_ERROR;
                        bus.o_error    <= ERR_TIMEOUT;
                        bus.o_cpu_hold <= 1'b0;
                    end
                end
                S_WRITE: begin
                    bus.o_write_en   <= 1'b0;
                    addr             <= addr_next;
                    bus.o_word_count <= bus.o_word_count + ADDR_WIDTH'(1);
                    if (bus.o_data == HALT_WORD) begin
                        state          <= S_DONE;
                        bus.o_done     <= 1'b1;
                        bus.o_cpu_hold <= 1'b0;
                    end else if (addr_next == ADDR_LIMIT) begin
                        // Stop before the first address past the end is ever written.
                        state          <= S_ERROR;
                        bus.o_error    <= ERR_OVERFLOW;
                        bus.o_cpu_hold <= 1'b0;
                    end else begin
                        state <= S_RECV;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares every o_write_en pulse.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       i_clk    = 1'b0;
    logic       i_reset  = 1'b0;
    logic       start    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       sel      = 1'b0;   // 0: 64-word instance, 1: 4-word instance

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t got_a;
    wr_t got_b;
    logic prev_we_a = 1'b0;
    logic prev_we_b = 1'b0;

    imem_loader_if #(.ADDR_WIDTH(32)) bus_a ();
    imem_loader_if #(.ADDR_WIDTH(32)) bus_b ();

    assign bus_a.i_start    = start && !sel;
    assign bus_a.i_rx_valid = rx_valid && !sel;
    assign bus_a.i_rx_data  = rx_data;
    assign bus_b.i_start    = start && sel;
    assign bus_b.i_rx_valid = rx_valid && sel;
    assign bus_b.i_rx_data  = rx_data;

    imem_loader #(
        .ADDR_WIDTH      (32),
        .MEM_DEPTH_WORDS (64),
        .HALT_WORD       (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_a)
    );

    imem_loader #(
        .ADDR_WIDTH      (32),
        .MEM_DEPTH_WORDS (4),
        .HALT_WORD       (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_b)
    );

    always #5 i_clk = ~i_clk;

    // Outputs of whichever instance is currently selected.
    logic        cur_we, cur_hold, cur_done;
    logic [1:0]  cur_err;
    logic [31:0] cur_count, cur_addr, cur_data;
    assign cur_we    = sel ? bus_b.o_write_en   : bus_a.o_write_en;
    assign cur_hold  = sel ? bus_b.o_cpu_hold   : bus_a.o_cpu_hold;
    assign cur_done  = sel ? bus_b.o_done       : bus_a.o_done;
    assign cur_err   = sel ? bus_b.o_error      : bus_a.o_error;
    assign cur_count = sel ? bus_b.o_word_count : bus_a.o_word_count;
    assign cur_addr  = sel ? bus_b.o_addr_wr    : bus_a.o_addr_wr;
    assign cur_data  = sel ? bus_b.o_data       : bus_a.o_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 64-word instance.
    always @(negedge i_clk) begin
        if (bus_a.o_write_en) begin
            check("we_a_single_cycle", {63'd0, prev_we_a}, 64'd0);
            if (exp_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write_a: got addr %0h data %0h, expected no write",
                         bus_a.o_addr_wr, bus_a.o_data);
            end else begin
                got_a = exp_a.pop_front();
                check("wr_addr_a", {32'd0, bus_a.o_addr_wr}, {32'd0, got_a.addr});
                check("wr_data_a", {32'd0, bus_a.o_data},    {32'd0, got_a.data});
            end
        end
        prev_we_a <= bus_a.o_write_en;
    end

    // Monitor for the 4-word instance.
    always @(negedge i_clk) begin
        if (bus_b.o_write_en) begin
            check("we_b_single_cycle", {63'd0, prev_we_b}, 64'd0);
            if (exp_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write_b: got addr %0h data %0h, expected no write",
                         bus_b.o_addr_wr, bus_b.o_data);
            end else begin
                got_b = exp_b.pop_front();
                check("wr_addr_b", {32'd0, bus_b.o_addr_wr}, {32'd0, got_b.addr});
                check("wr_data_b", {32'd0, bus_b.o_data},    {32'd0, got_b.data});
            end
        end
        prev_we_b <= bus_b.o_write_en;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
    endtask

    // One-cycle byte strobe; on a word's last byte, check whether the write
    // pulse appears in the very next cycle.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit last, input bit wr);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (last) check(wr ? "we_latency" : "we_suppressed", {63'd0, cur_we}, {63'd0, wr});
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit wr,
                             input logic [31:0] addr);
        logic [31:0] sh;
        sh = w;
        if (wr) push_exp(addr, w);
        for (int i = 0; i < 4; i++) begin
            send_byte(sh[31:24], gap, i == 3, wr);
            sh = sh << 8;
        end
    endtask

    initial begin
        int cycles;

        // Reset held for two edges.
        i_reset = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        check("rst_we",    {63'd0, cur_we},    64'd0);
        check("rst_addr",  {32'd0, cur_addr},  64'd0);
        check("rst_data",  {32'd0, cur_data},  64'd0);
        check("rst_hold",  {63'd0, cur_hold},  64'd0);
        check("rst_done",  {63'd0, cur_done},  64'd0);
        check("rst_err",   {62'd0, cur_err},   64'd0);
        check("rst_count", {32'd0, cur_count}, 64'd0);

        // Bytes in IDLE are ignored: the monitor flags any write.
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0, 1'b0, 1'b0);
        tick();
        check("idle_hold", {63'd0, cur_hold}, 64'd0);

        // Basic program with one idle cycle between bytes.
        do_start();
        check("start_hold", {63'd0, cur_hold}, 64'd1);
        send_word(32'h2008_0005, 1, 1'b1, 32'd0);
        send_word(32'h2009_000A, 1, 1'b1, 32'd4);
        send_word(32'hFFFF_FFFF, 1, 1'b1, 32'd8);
        check("prog_done",  {63'd0, cur_done},  64'd1);
        check("prog_count", {32'd0, cur_count}, 64'd3);
        check("prog_hold",  {63'd0, cur_hold},  64'd0);
        check("prog_err",   {62'd0, cur_err},   64'd0);

        // Back-to-back bytes; byte 0 of word 2 arrives during the WRITE cycle.
        do_start();
        check("restart_done",  {63'd0, cur_done},  64'd0);
        check("restart_count", {32'd0, cur_count}, 64'd0);
        send_word(32'h1122_3344, 0, 1'b1, 32'd0);
        send_word(32'h5566_7788, 0, 1'b1, 32'd4);
        send_word(32'hFFFF_FFFF, 0, 1'b1, 32'd8);
        tick();
        check("b2b_done",  {63'd0, cur_done},  64'd1);
        check("b2b_count", {32'd0, cur_count}, 64'd3);

        // Timeout after three bytes of a word.
        do_start();
        send_byte(8'hDE, 0, 1'b0, 1'b0);
        send_byte(8'hAD, 0, 1'b0, 1'b0);
        send_byte(8'hBE, 0, 1'b0, 1'b0);
        cycles = 0;
        while (cur_err == 2'b00 && cycles < TIMEOUT + 10) begin
            tick();
            cycles++;
        end
        check("timeout_cycles", 64'(cycles), 64'(TIMEOUT));
        check("timeout_err",    {62'd0, cur_err},   64'h1);
        check("timeout_hold",   {63'd0, cur_hold},  64'd0);
        check("timeout_done",   {63'd0, cur_done},  64'd0);
        check("timeout_count",  {32'd0, cur_count}, 64'd0);

        // Overflow on the 4-word instance.
        sel = 1'b1;
        do_start();
        send_word(32'h0102_0304, 1, 1'b1, 32'd0);
        send_word(32'h0506_0708, 1, 1'b1, 32'd4);
        send_word(32'h090A_0B0C, 1, 1'b1, 32'd8);
        send_word(32'h0D0E_0F10, 1, 1'b1, 32'd12);
        check("ovf_err",   {62'd0, cur_err},   64'h2);
        check("ovf_count", {32'd0, cur_count}, 64'd4);
        check("ovf_hold",  {63'd0, cur_hold},  64'd0);
        check("ovf_done",  {63'd0, cur_done},  64'd0);
        send_word(32'h1111_1111, 0, 1'b0, 32'd16);
        sel = 1'b0;

        // Reset mid-word, then a fresh load whose start coincides with a byte.
        do_start();
        send_byte(8'hAA, 0, 1'b0, 1'b0);
        send_byte(8'hBB, 0, 1'b0, 1'b0);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        check("midrst_hold",  {63'd0, cur_hold},  64'd0);
        check("midrst_count", {32'd0, cur_count}, 64'd0);
        check("midrst_err",   {62'd0, cur_err},   64'd0);
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        send_word(32'h200C_0019, 1, 1'b1, 32'd0);
        send_word(32'hFFFF_FFFF, 1, 1'b1, 32'd4);
        check("fresh_done",  {63'd0, cur_done},  64'd1);
        check("fresh_count", {32'd0, cur_count}, 64'd2);

        repeat (3) tick();
        check("exp_a_drained", 64'(exp_a.size()), 64'd0);
        check("exp_b_drained", 64'(exp_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected end before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
